wb_regfile_hilo: RTL
====================

// Module: wb_regfile_hilo
// PURPOSE
//  Writeback-side sink of the MEM/WB pipeline register: consumes the wb_* bus (GPR write, HI/LO write).
//  Holds 32x32 general register file ($0 hardwired zero) and architectural HI/LO pair.
//  Serves two ID-stage GPR read ports and one EX-stage HI/LO read port; same-cycle write-through bypass.
//  Counts retired writeback events for debug/perf.
// PARAMETERS
//  DATA_W   32  register/data width
//  ADDR_W   5   GPR address width
//  NREG     32  number of GPRs (= 2**ADDR_W)
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  rst           in   1       synchronous, active-high reset
//  wb_wd         in   ADDR_W  GPR write address
//  wb_wreg       in   1       GPR write enable
//  wb_wdata      in   DATA_W  GPR write data
//  wb_hi         in   DATA_W  HI write data
//  wb_lo         in   DATA_W  LO write data
//  wb_whilo      in   1       HI/LO write enable (writes both)
//  re1 / raddr1  in   1/ADDR_W  read port 1 enable/address
//  re2 / raddr2  in   1/ADDR_W  read port 2 enable/address
//  rdata1        out  DATA_W  read port 1 data (combinational)
//  rdata2        out  DATA_W  read port 2 data (combinational)
//  hi_o / lo_o   out  DATA_W  current HI/LO value (combinational, bypassed)
//  retire_cnt    out  32      count of cycles with wb_wreg|wb_whilo (registered)
// BEHAVIOUR
//  Reset: reset rst, synchronous, active-high; clock clk. On posedge with rst=1: all GPRs, HI, LO,
//   retire_cnt <= 0. Write inputs ignored that cycle (reset wins over simultaneous write).
//   While rst=1: rdata1, rdata2, hi_o, lo_o driven 0 regardless of state/bypass.
//  GPR write: posedge, rst=0, wb_wreg=1, wb_wd!=0 -> gpr[wb_wd] <= wb_wdata. wb_wd==0: no write.
//  HI/LO write: posedge, rst=0, wb_whilo=1 -> HI<=wb_hi, LO<=wb_lo (always as a pair). Independent of wb_wreg.
//  Read port n (priority order):
//   1. rst=1 -> 0;  2. raddrn==0 -> 0;  3. ren=0 -> 0;
//   4. wb_wreg=1 && wb_wd==raddrn -> wb_wdata (bypass, zero-latency);  5. else gpr[raddrn].
//  HI/LO read: rst=1 -> 0; wb_whilo=1 -> {wb_hi,wb_lo} bypass; else stored HI/LO.
//  Read latency 0 (combinational); write visible in storage next cycle, via bypass same cycle.
//  Both read ports may address same register; both return identical data incl. bypass.
//  retire_cnt: +1 per posedge with rst=0 and (wb_wreg|wb_whilo); 0xFFFF_FFFF wraps to 0.
//   wb_wreg=1 with wb_wd=0 still counts (retired, discarded write).
//  No stall/flush inputs: MEM/WB register already delivers bubbles as wb_wreg=0, wb_whilo=0.
//  Widths: no arithmetic on data; addresses compared full ADDR_W bits; no X propagation from
//   uninitialised storage after reset.
// TESTING
//  T1 reset: write random regs, assert rst 1 cycle -> all 31 GPRs, HI, LO read 0; retire_cnt=0.
//  T2 write/read: wb_wd=5,wb_wreg=1,wb_wdata=0xDEADBEEF; next cycle raddr1=5,re1=1 -> rdata1=0xDEADBEEF.
//  T3 bypass: same-cycle wb_wd=7,wdata=0x1234 and raddr1=raddr2=7 -> both =0x1234 that cycle;
//   with re2=0 -> rdata2=0.
//  T4 $0: wb_wd=0,wb_wreg=1,wdata=0xFFFFFFFF; raddr1=0 same and next cycle -> 0; retire_cnt increments.
//  T5 HI/LO: wb_whilo=1,hi=0xAAAA0000,lo=0x0000BBBB -> hi_o/lo_o same cycle and hold after whilo=0;
//   rst asserted with whilo=1 -> HI/LO=0 next cycle.
//  T6 counter: preload via 2^32-1 events (or force) then one event -> retire_cnt wraps to 0.

Source files
------------

// File: rtl/wb_regfile_hilo.sv
// Writeback-side register file: 32 GPRs ($0 hardwired to zero), the HI/LO
// pair, two combinational GPR read ports and one HI/LO read port with
// same-cycle write-through bypass, and a retired-writeback event counter.
module wb_regfile_hilo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [31:0]       retire_cnt
);

    logic [DATA_W-1:0] gpr_q [NREG];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [31:0]       retire_cnt_q;
    logic [31:0]       retire_cnt_d;

    // GPR storage: reset clears every entry; writes to $0 are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != '0)) begin
            gpr_q[wb_wd] <= wb_wdata;
        end
    end

    // HI/LO are always written together, independently of the GPR write
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // Retire counter next state: any writeback event counts, even a write to $0
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (wb_wreg || wb_whilo) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // Retire counter register, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

    // Read port 1: reset, $0 and disabled reads give zero, then bypass, then storage
    always_comb begin
        rdata1 = '0;
        if (!rst && (raddr1 != '0) && re1) begin
            if (wb_wreg && (wb_wd == raddr1)) begin
                rdata1 = wb_wdata;
            end else begin
                rdata1 = gpr_q[raddr1];
            end
        end
    end

    // Read port 2: identical priority to port 1
    always_comb begin
        rdata2 = '0;
        if (!rst && (raddr2 != '0) && re2) begin
            if (wb_wreg && (wb_wd == raddr2)) begin
                rdata2 = wb_wdata;
            end else begin
                rdata2 = gpr_q[raddr2];
            end
        end
    end

    // HI/LO read: zero in reset, bypass a pending pair write, else stored pair
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            if (wb_whilo) begin
                hi_o = wb_hi;
                lo_o = wb_lo;
            end else begin
                hi_o = hi_q;
                lo_o = lo_q;
            end
        end
    end

endmodule
